// File: rtl/button_event_arbiter.sv
// Queues one pending event per button and serves them round-robin over valid/ready.
// Optional BTN_DROP_CNT_EN adds a saturating drop counter with synchronous clear.
module button_event_arbiter #(
  parameter int unsigned NUM_BUTTONS = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_BUTTONS-1:0]         rise,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] evt_id,
  output logic [NUM_BUTTONS-1:0]         pending,
  output logic                           drop
`ifdef BTN_DROP_CNT_EN
  ,
  input  logic                           drop_clr,
  output logic [7:0]                     drop_count
`endif
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_BUTTONS);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e                  state_q;
  logic [ID_WIDTH-1:0]     last_grant_q;
  logic [NUM_BUTTONS-1:0]  accepted_mask;
  logic [NUM_BUTTONS-1:0]  pending_d;
  logic                    drop_d;
  logic                    grant_found;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic [ID_WIDTH-1:0]     cand_idx;
  int unsigned             cand;

  always_comb begin
    accepted_mask = '0;
    if (state_q == StOffer && evt_ready) begin
      accepted_mask[evt_id] = 1'b1;
    end
    // A press coinciding with its own accept is re-queued, not dropped.
    pending_d = (pending & ~accepted_mask) | rise;
    drop_d    = |(rise & pending & ~accepted_mask);
  end

  // First set pending bit searching upward from last_grant+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_BUTTONS; k++) begin
      cand     = (32'(last_grant_q) + k) % NUM_BUTTONS;
      cand_idx = cand[ID_WIDTH-1:0];
      if (!grant_found && pending[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= ID_WIDTH'(NUM_BUTTONS - 1);
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      pending      <= '0;
      drop         <= 1'b0;
    end else begin
      pending <= pending_d;
      drop    <= drop_d;
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            evt_id    <= grant_idx;
            evt_valid <= 1'b1;
            state_q   <= StOffer;
          end
        end
        StOffer: begin
          if (evt_ready) begin
            last_grant_q <= evt_id;
            evt_valid    <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BTN_DROP_CNT_EN
  // Clear has priority over a coincident drop pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (drop_clr) begin
      drop_count <= 8'd0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter (4 buttons).
// Covers the drop counter too when BTN_DROP_CNT_EN is defined.
module tb_button_event_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] rise;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic       drop;
`ifdef BTN_DROP_CNT_EN
  logic       drop_clr;
  logic [7:0] drop_count;
`endif

  int n_cmp;
  int n_err;

  button_event_arbiter #(
    .NUM_BUTTONS(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rise      (rise),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .drop      (drop)
`ifdef BTN_DROP_CNT_EN
    ,
    .drop_clr  (drop_clr),
    .drop_count(drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  logic [3:0] exp_p;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rise      = '0;
    evt_ready = 1'b0;
    reset_n   = 1'b0;
`ifdef BTN_DROP_CNT_EN
    drop_clr  = 1'b0;
`endif
    #12;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single press on button 2, ready held
    evt_ready = 1'b1;
    rise = 4'b0100;
    tick();
    check("t1_pend", 32'(pending), 32'h4);
    check("t1_valid_early", 32'(evt_valid), 32'd0);
    rise = 4'b0000;
    tick();
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_id", 32'(evt_id), 32'd2);
    tick();
    check("t1_valid_off", 32'(evt_valid), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'd0);
    check("t1_drop", 32'(drop), 32'd0);

    // 2: all four at once, served 0..3 after reset
    do_reset();
    rise = 4'b1111;
    tick();
    check("t2_pend", 32'(pending), 32'hF);
    rise = 4'b0000;
    exp_p = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_valid", 32'(evt_valid), 32'd1);
      check("t2_id", 32'(evt_id), 32'(k));
      tick();
      exp_p[k] = 1'b0;
      check("t2_valid_off", 32'(evt_valid), 32'd0);
      check("t2_pend", 32'(pending), 32'(exp_p));
    end

    // 3: double press on button 1 while stalled
    evt_ready = 1'b0;
    rise = 4'b0010;
    tick();
    check("t3_pend", 32'(pending), 32'h2);
    rise = 4'b0000;
    tick();
    check("t3_valid", 32'(evt_valid), 32'd1);
    check("t3_id", 32'(evt_id), 32'd1);
    tick();
    check("t3_id_hold", 32'(evt_id), 32'd1);
    check("t3_drop_pre", 32'(drop), 32'd0);
    rise = 4'b0010;
    tick();
    check("t3_drop", 32'(drop), 32'd1);
    check("t3_valid_hold", 32'(evt_valid), 32'd1);
    rise = 4'b0000;
    tick();
    check("t3_drop_end", 32'(drop), 32'd0);
    check("t3_id_hold2", 32'(evt_id), 32'd1);
    evt_ready = 1'b1;
    tick();
    check("t3_valid_off", 32'(evt_valid), 32'd0);
    check("t3_pend_clr", 32'(pending), 32'd0);
    tick();
    check("t3_no_second", 32'(evt_valid), 32'd0);

    // 4: press on button 3 in the same cycle it is accepted
    evt_ready = 1'b0;
    rise = 4'b1000;
    tick();
    rise = 4'b0000;
    tick();
    check("t4_id", 32'(evt_id), 32'd3);
    check("t4_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    rise = 4'b1000;
    tick();
    check("t4_pend_kept", 32'(pending), 32'h8);
    check("t4_drop", 32'(drop), 32'd0);
    check("t4_valid_off", 32'(evt_valid), 32'd0);
    rise = 4'b0000;
    tick();
    check("t4_reoffer", 32'(evt_valid), 32'd1);
    check("t4_reoffer_id", 32'(evt_id), 32'd3);
    tick();
    check("t4_pend_clr", 32'(pending), 32'd0);

    // 5: serve 2, then 0 and 3 together -> 3 first (wrap)
    rise = 4'b0100;
    tick();
    rise = 4'b0000;
    tick();
    check("t5_id2", 32'(evt_id), 32'd2);
    tick();
    rise = 4'b1001;
    tick();
    check("t5_pend", 32'(pending), 32'h9);
    rise = 4'b0000;
    tick();
    check("t5_first", 32'(evt_id), 32'd3);
    tick();
    check("t5_pend_mid", 32'(pending), 32'h1);
    tick();
    check("t5_second", 32'(evt_id), 32'd0);
    check("t5_valid", 32'(evt_valid), 32'd1);
    tick();
    check("t5_pend_clr", 32'(pending), 32'd0);

    // 6: asynchronous reset mid-offer
    evt_ready = 1'b0;
    rise = 4'b1010;
    tick();
    rise = 4'b0000;
    tick();
    check("t6_valid", 32'(evt_valid), 32'd1);
    check("t6_id", 32'(evt_id), 32'd1);
    rise = 4'b0010;
    tick();
    check("t6_pend", 32'(pending), 32'hA);
    check("t6_drop", 32'(drop), 32'd1);
    rise = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_pend", 32'(pending), 32'd0);
    check("t6_async_drop", 32'(drop), 32'd0);
    check("t6_async_id", 32'(evt_id), 32'd0);
    #2;
    reset_n = 1'b1;
    evt_ready = 1'b1;
    rise = 4'b1001;
    tick();
    rise = 4'b0000;
    tick();
    check("t6_post_id", 32'(evt_id), 32'd0);
    check("t6_post_valid", 32'(evt_valid), 32'd1);

`ifdef BTN_DROP_CNT_EN
    // Saturating drop counter and clear
    do_reset();
    check("dc_rst", 32'(drop_count), 32'd0);
    evt_ready = 1'b0;
    rise = 4'b0001;
    for (int i = 0; i < 302; i++) tick();
    check("dc_sat", 32'(drop_count), 32'd255);
    drop_clr = 1'b1;
    tick();
    check("dc_clr_wins", 32'(drop_count), 32'd0);
    drop_clr = 1'b0;
    tick();
    check("dc_after_clr", 32'(drop_count), 32'd1);
    rise = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Collects single-cycle rise pulses from NUM_BUTTONS debounce instances and queues one pending event per button. It serves the pending events in round-robin order to a single consumer, such as the blinky mode/LED controller, over a valid/ready handshake. A press is never lost while its button has no event pending. A press that arrives while its button's event is still pending is flagged as dropped.

Parameters:
NUM_BUTTONS, 4, number of debounced button channels; legal range 2..16.
ID_WIDTH, $clog2(NUM_BUTTONS), width of the event ID; derived localparam, not overridable.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
rise  input  NUM_BUTTONS  one-cycle rise pulses from the debounce instances, synchronous to clock; bit i belongs to button i.
evt_valid  output  1  an event is being offered to the consumer.
evt_ready  input  1  the consumer accepts the offered event.
evt_id  output  ID_WIDTH  index of the button being offered; stable while evt_valid=1.
pending  output  NUM_BUTTONS  registered per-button pending flags, for status display.
drop  output  1  one-cycle pulse: a rise was lost because that button's event was already pending.

Behaviour:
- Reset (asynchronous assert on reset_n=0):
  - pending=0, evt_valid=0, evt_id=0, drop=0.
  - last_grant=NUM_BUTTONS-1, so button 0 has first priority after reset.
  - State is IDLE.
  - The deassertion edge needs no special handling.
- Pending flags, evaluated per bit i each cycle:
  - The bit is "accepted" when state=OFFER, evt_ready=1 and evt_id=i.
  - Next pending[i] = (pending[i] & ~accepted_i) | rise[i].
  - When rise[i] and accepted_i occur in the same cycle, pending[i] stays 1. The new press is queued, not dropped.
  - drop is registered: drop <= |(rise & pending & ~accepted_mask).
- State machine (2 states):
  - IDLE:
    - If any pending bit is set, pick the first set bit searching upward from last_grant+1, wrapping from NUM_BUTTONS-1 to 0.
    - Register that index into evt_id, set evt_valid=1, go to OFFER.
    - If no bit is set, stay in IDLE with evt_valid=0.
    - Arbitration uses the registered pending value. A rise in this cycle is not visible until the next cycle.
  - OFFER:
    - evt_valid=1 and evt_id are held constant until evt_ready=1.
    - On evt_ready=1, the handshake completes in that cycle: clear pending[evt_id], set last_grant<=evt_id, set evt_valid<=0, go to IDLE.
    - The next grant is made no earlier than the following cycle. Maximum throughput is one event per 2 cycles.
    - evt_ready while in IDLE has no effect.
- Latency: rise[i] at cycle t gives pending[i]=1 at t+1. If the FSM was in IDLE with nothing else pending, evt_valid=1 with evt_id=i at t+2.
- Fairness: after button k is served, every other pending button is served before k is served again.
- Inputs are not re-synchronised. rise must come from logic clocked by clock.
- Reset asserted mid-OFFER: the offered event and all pending events are discarded. evt_valid falls immediately (asynchronously).

Optional Feature:
Macro: BTN_DROP_CNT_EN
- Defined:
  - Adds output drop_count, 8 bits: a saturating count of drop pulses, held at 255 once reached.
  - Adds input drop_clr, 1 bit: synchronous clear of the count.
  - If drop_clr and a drop pulse occur in the same cycle, the clear wins and the count becomes 0.
  - drop_count resets to 0 on reset_n.
- Not defined: these ports and the counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then rise=4'b0100 for 1 cycle, evt_ready=1 held -> evt_valid=1 with evt_id=2 exactly 2 cycles after the pulse, for 1 cycle; pending returns to 0; drop stays 0.
2. rise=4'b1111 in one cycle, evt_ready=1 held -> events are offered in order 0,1,2,3, one every 2 cycles; pending is 0 after the last accept.
3. Hold evt_ready=0 and pulse rise[1] twice, 3 cycles apart -> evt_id=1 is offered and held stable; drop pulses once, 1 cycle after the second pulse; exactly one event for button 1 is delivered after evt_ready=1.
4. While evt_id=3 is being accepted (evt_ready=1), rise[3]=1 in the same cycle -> pending[3] remains 1, drop=0, and a second event for button 3 is offered later.
5. Serve button 2, then pulse rise[0] and rise[3] together -> button 3 is served before button 0 (round-robin from last_grant=2, wrapping).
6. Assert reset_n=0 while evt_valid=1 with pending=4'b1010 -> evt_valid, pending and drop go to 0 without waiting for a clock edge; after release the next grant starts at button 0. With BTN_DROP_CNT_EN defined, also check that 300 drops give drop_count=255 and that drop_clr returns it to 0.
